// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM state encodings
// and the supported operand width range.
package alu_pkg;

    localparam int unsigned WidthMin     = 8;
    localparam int unsigned WidthMax     = 64;
    localparam int unsigned WidthDefault = 32;

    typedef enum logic [3:0] {
        OpAnd  = 4'd0,
        OpOr   = 4'd1,
        OpAdd  = 4'd2,
        OpSub  = 4'd3,
        OpNeg  = 4'd4,
        OpNot  = 4'd5,
        OpShr  = 4'd6,
        OpShra = 4'd7,
        OpShl  = 4'd8,
        OpRor  = 4'd9,
        OpRol  = 4'd10,
        OpMul  = 4'd11,
        OpDiv  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative signed divider (non-restoring core on magnitudes, one quotient bit per cycle).
// Only built when ALU_SEQ_DIV_EN is defined; done_o is high for the single cycle results are valid.
`ifdef ALU_SEQ_DIV_EN
module alu_seq_div
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             active_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] rem_mag;

    always_comb begin
        a_mag     = dividend_i[WIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
        b_mag     = divisor_i[WIDTH-1] ? (~divisor_i + 1'b1) : divisor_i;
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        // Negative partial remainder: add the divisor back instead of restoring.
        rem_step  = rem_q[WIDTH] ? (rem_shift + {1'b0, dvs_q}) : (rem_shift - {1'b0, dvs_q});
        rem_mag   = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_q) : rem_q[WIDTH-1:0];
    end

    assign done_o      = active_q && (cnt_q == CntW'(WIDTH));
    assign quotient_o  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    assign remainder_o = r_neg_q ? (~rem_mag + 1'b1) : rem_mag;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvs_q    <= b_mag;
            q_neg_q  <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            r_neg_q  <= dividend_i[WIDTH-1];
        end else if (active_q) begin
            if (cnt_q == CntW'(WIDTH)) begin
                active_q <= 1'b0;
            end else begin
                rem_q <= rem_step;
                quo_q <= {quo_q[WIDTH-2:0], ~rem_step[WIDTH]};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops, radix-4 Booth multiplier and an optional
// signed divider (enabled by defining ALU_SEQ_DIV_EN; otherwise DIV behaves as an unused opcode).
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] Rb,
    input  logic [WIDTH-1:0] Ry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi,
    output logic             div_by_zero
);

    localparam int unsigned ShW     = $clog2(WIDTH);
    localparam int unsigned MulIter = WIDTH / 2;
    localparam int unsigned CntW    = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CntW-1:0]    cnt_q;
    logic signed [WIDTH+1:0] mhi_q;
    logic [WIDTH-1:0]   mlo_q;
    logic               mprev_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;

    logic               accept;
    logic [ShW-1:0]     amt;
    logic [WIDTH-1:0]   simple_res;
    logic               simple_op;
    logic signed [WIDTH+1:0] m_ext;
    logic signed [WIDTH+1:0] pp;
    logic signed [WIDTH+1:0] msum;

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        amt        = b_q[ShW-1:0];
        simple_op  = 1'b1;
        simple_res = '0;
        case (op_q)
            OpAnd:   simple_res = a_q & b_q;
            OpOr:    simple_res = a_q | b_q;
            OpAdd:   simple_res = a_q + b_q;
            OpSub:   simple_res = a_q - b_q;
            OpNeg:   simple_res = ~a_q + 1'b1;
            OpNot:   simple_res = ~a_q;
            OpShr:   simple_res = a_q >> amt;
            OpShra:  simple_res = $signed(a_q) >>> amt;
            OpShl:   simple_res = a_q << amt;
            OpRor:   simple_res = (a_q >> amt) | (a_q << (WIDTH - 32'(amt)));
            OpRol:   simple_res = (a_q << amt) | (a_q >> (WIDTH - 32'(amt)));
            default: simple_op  = 1'b0;
        endcase
    end

    // Booth digit from multiplier bits {b[2k+1], b[2k], b[2k-1]}.
    always_comb begin
        m_ext = {{2{a_q[WIDTH-1]}}, a_q};
        case ({mlo_q[1:0], mprev_q})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext <<< 1;
            3'b100:         pp = -(m_ext <<< 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        msum = mhi_q + pp;
    end

`ifdef ALU_SEQ_DIV_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign div_start = accept && (op == OpDiv) && (Ry != '0);

    alu_seq_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk_i       (clk),
        .rst_ni      (clr),
        .start_i     (div_start),
        .dividend_i  (Rb),
        .divisor_i   (Ry),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            mhi_q   <= '0;
            mlo_q   <= '0;
            mprev_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StExec;
                        busy_q  <= 1'b1;
                        op_q    <= op;
                        a_q     <= Rb;
                        b_q     <= Ry;
                        dbz_q   <= 1'b0;
                        cnt_q   <= '0;
                        mhi_q   <= '0;
                        mlo_q   <= Ry;
                        mprev_q <= 1'b0;
                    end
                end
                StExec: begin
                    if (simple_op) begin
                        lo_q    <= simple_res;
                        hi_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (op_q == OpMul) begin
                        if (cnt_q == CntW'(MulIter)) begin
                            lo_q    <= mlo_q;
                            hi_q    <= mhi_q[WIDTH-1:0];
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            mhi_q   <= {{2{msum[WIDTH+1]}}, msum[WIDTH+1:2]};
                            mlo_q   <= {msum[1:0], mlo_q[WIDTH-1:2]};
                            mprev_q <= mlo_q[1];
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (op_q == OpDiv) begin
                        if (b_q == '0) begin
                            lo_q    <= '1;
                            hi_q    <= a_q;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (div_done) begin
                            lo_q    <= div_quo;
                            hi_q    <= div_rem;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
`endif
                    else begin
                        lo_q    <= '0;
                        hi_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign resultLo    = lo_q;
    assign resultHi    = hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); DIV vectors depend on whether ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

    localparam int unsigned W = 32;

    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpOr   = 4'd1;
    localparam logic [3:0] OpAdd  = 4'd2;
    localparam logic [3:0] OpSub  = 4'd3;
    localparam logic [3:0] OpNeg  = 4'd4;
    localparam logic [3:0] OpNot  = 4'd5;
    localparam logic [3:0] OpShr  = 4'd6;
    localparam logic [3:0] OpShra = 4'd7;
    localparam logic [3:0] OpShl  = 4'd8;
    localparam logic [3:0] OpRor  = 4'd9;
    localparam logic [3:0] OpRol  = 4'd10;
    localparam logic [3:0] OpMul  = 4'd11;
    localparam logic [3:0] OpDiv  = 4'd12;

    logic         clk;
    logic         clr;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] Rb;
    logic [W-1:0] Ry;
    logic         busy;
    logic         done;
    logic [W-1:0] resultLo;
    logic [W-1:0] resultHi;
    logic         div_by_zero;

    int n_checks;
    int n_fail;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .Rb          (Rb),
        .Ry          (Ry),
        .busy        (busy),
        .done        (done),
        .resultLo    (resultLo),
        .resultHi    (resultHi),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drives one request, scrambles inputs after acceptance, returns cycles from accept to done.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, output int lat);
        op    = o;
        Rb    = a;
        Ry    = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = poke;
        op    = OpAdd;
        Rb    = ~a;
        Ry    = ~b;
        lat   = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 3) start = 1'b0;
            if (done) break;
        end
        if (!done) check_eq("timeout", 64'(done), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic exp_dbz, input int exp_lat);
        int lat;
        run_op(o, a, b, 1'b0, lat);
        check_eq({tag, "_lo"}, 64'(resultLo), 64'(exp_lo));
        check_eq({tag, "_hi"}, 64'(resultHi), 64'(exp_hi));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {62'b0, done, busy}, 64'd0);
        check_eq({tag, "_hold"}, {resultHi, resultLo}, {exp_hi, exp_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b0;
        start    = 1'b0;
        op       = '0;
        Rb       = '0;
        Ry       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", {61'b0, busy, done, div_by_zero}, 64'd0);
        check_eq("rst_res", {resultHi, resultLo}, 64'd0);

        // Start is driven in the same cycle the reset is released.
        @(negedge clk);
        clr = 1'b1;
        do_op("add", OpAdd, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1);
        do_op("add_wrap", OpAdd, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1);
        do_op("sub", OpSub, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'd0, 1'b0, 1);
        do_op("and", OpAnd, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'd0, 1'b0, 1);
        do_op("or", OpOr, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'd0, 1'b0, 1);
        do_op("neg", OpNeg, 32'd1, 32'd9, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        do_op("not", OpNot, 32'h0F0F_0F0F, 32'd0, 32'hF0F0_F0F0, 32'd0, 1'b0, 1);
        do_op("shr", OpShr, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0, 1'b0, 1);
        do_op("shra", OpShra, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0, 1'b0, 1);
        do_op("shl", OpShl, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1);
        do_op("ror", OpRor, 32'd1, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1);
        do_op("rol", OpRol, 32'h8000_0001, 32'h0000_0024, 32'h0000_0018, 32'd0, 1'b0, 1);

        do_op("mul_neg", OpMul, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 17);
        do_op("mul_minsq", OpMul, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000, 1'b0, 17);
        do_op("mul_small", OpMul, 32'h1234_5678, 32'd2, 32'h2468_ACF0, 32'd0, 1'b0, 17);
        do_op("mul_m1sq", OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 17);
        do_op("mul_mix", OpMul, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000,
              1'b0, 17);
        do_op("op13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0, 1);
        do_op("op15", 4'd15, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 1);

`ifdef ALU_SEQ_DIV_EN
        do_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        do_op("div_negdvs", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        do_op("div_pos", OpDiv, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        do_op("div_zero", OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
        do_op("dbz_clear", OpAdd, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1);
`else
        do_op("div_off", OpDiv, 32'd7, 32'd2, 32'd0, 32'd0, 1'b0, 1);
        do_op("div_off_z", OpDiv, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1);
`endif

        // Asynchronous reset in the middle of a multiply, with non-zero results held.
        do_op("mul_pre", OpMul, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 17);
        op    = OpMul;
        Rb    = 32'd3;
        Ry    = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        check_eq("midrst_flags", {61'b0, busy, done, div_by_zero}, 64'd0);
        check_eq("midrst_res", {resultHi, resultLo}, 64'd0);
        @(negedge clk);
        clr = 1'b1;

        // Start held high for a few busy cycles must neither disturb nor queue.
        run_op(OpMul, 32'hFFFF_FFFD, 32'd7, 1'b1, lat);
        check_eq("poke_lo", 64'(resultLo), 64'hFFFF_FFEB);
        check_eq("poke_hi", 64'(resultHi), 64'hFFFF_FFFF);
        check_eq("poke_lat", 64'(lat), 64'd17);
        repeat (2) @(posedge clk);
        #1;
        check_eq("no_queue", {62'b0, busy, done}, 64'd0);

        do_op("add_after", OpAdd, 32'd10, 32'd20, 32'd30, 32'd0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
